// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: frame-parser states, abort codes and the default frame header byte
package uart_cmd_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM, S_WRITE} state_t;
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CSUM    = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_LINE    = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;
    localparam logic [2:0] ERR_ACK     = 3'd5;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h55;
endpackage

// File: rtl/uart_cmd_ctrl_timer.sv
// uart_cmd_ctrl_timer: restartable down-counter; expire flags the last allowed cycle while enabled
module uart_cmd_ctrl_timer #(
    parameter int unsigned COUNT = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = (COUNT > 2) ? $clog2(COUNT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? W'(COUNT - 1) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    assign expire = en && !load && cnt_q == '0;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses {HDR,ADDR,DHI,DLO,CSUM} UART frames into req/ack config-register writes
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CNT = 270000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_frame_error,
    input  logic             rx_chk_error,
    output logic             rx_clear,
    output logic [7:0]       cfg_addr,
    output logic [15:0]      cfg_wdata,
    output logic             cfg_req,
    input  logic             cfg_ack,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);
    state_t state_q, state_d;
    logic [2:0] err_code_q, err_code_d, abort_code;
    logic [7:0] addr_q, addr_d, sum_q, sum_d, sum_next;
    logic [15:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
    logic frame_ok_q, frame_ok_d, frame_err_q, rx_clear_q;
    logic abort, line_err, data_byte, tmr_load, expire;

    assign line_err  = rx_valid & (rx_frame_error | rx_chk_error);
    assign data_byte = rx_valid & ~line_err;
    assign sum_next  = sum_q + rx_data;

    uart_cmd_ctrl_timer #(.COUNT(TIMEOUT_CNT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .en     (state_q != S_IDLE),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sum_d      = sum_q;
        err_code_d = err_code_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        frame_ok_d = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;
        tmr_load   = 1'b0;
        case (state_q)
            S_IDLE: if (data_byte && rx_data == HDR_BYTE) begin
                state_d  = S_ADDR;
                sum_d    = '0;
                tmr_load = 1'b1;
            end
            S_ADDR, S_DHI, S_DLO: if (data_byte) begin
                state_d  = state_t'(state_q + 3'd1);
                sum_d    = sum_next;
                addr_d   = (state_q == S_ADDR) ? rx_data : addr_q;
                wdata_d  = (state_q == S_DHI) ? {rx_data, wdata_q[7:0]} :
                           (state_q == S_DLO) ? {wdata_q[15:8], rx_data} : wdata_q;
                tmr_load = 1'b1;
            end else if (line_err || expire) begin
                abort      = 1'b1;
                abort_code = line_err ? ERR_LINE : ERR_TIMEOUT;
            end
            S_CSUM: if (data_byte && sum_next == '0) begin
                state_d  = S_WRITE;
                tmr_load = 1'b1;
            end else if (rx_valid || expire) begin
                abort      = 1'b1;
                abort_code = data_byte ? ERR_CSUM : line_err ? ERR_LINE : ERR_TIMEOUT;
            end
            // an ack outranks any byte or timeout arriving in the same cycle
            S_WRITE: if (cfg_ack) begin
                state_d    = S_IDLE;
                frame_ok_d = 1'b1;
                ok_cnt_d   = (&ok_cnt_q) ? ok_cnt_q : ok_cnt_q + CNT_W'(1);
            end else if (rx_valid || expire) begin
                abort      = 1'b1;
                abort_code = line_err ? ERR_LINE : rx_valid ? ERR_OVERRUN : ERR_ACK;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d    = S_IDLE;
            err_code_d = abort_code;
            err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            sum_q       <= '0;
            err_code_q  <= '0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_clear_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sum_q       <= sum_d;
            err_code_q  <= err_code_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= abort;
            rx_clear_q  <= line_err;
        end
    end

    assign rx_clear  = rx_clear_q;
    assign cfg_addr  = addr_q;
    assign cfg_wdata = wdata_q;
    assign cfg_req   = state_q == S_WRITE;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign ok_cnt    = ok_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: frame vectors, corner sequences and random frames against a frame-level model
module tb_uart_cmd_ctrl;
    localparam int T    = 40;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0, rx_frame_error = 1'b0, rx_chk_error = 1'b0, cfg_ack = 1'b0;
    logic rx_clear, cfg_req, frame_ok, frame_err, busy;
    logic [7:0] cfg_addr;
    logic [15:0] cfg_wdata;
    logic [2:0] err_code;
    logic [CW-1:0] ok_cnt, err_cnt;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CNT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_error(rx_frame_error), .rx_chk_error(rx_chk_error), .rx_clear(rx_clear),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    int errors = 0, checks = 0;

    // reference model: a frame is a header followed by a collected list of four bytes
    bit m_in, m_wr, m_ok, m_err, m_clr;
    int m_idle, m_okc, m_errc;
    logic [2:0] m_code;
    logic [7:0] m_addr;
    logic [15:0] m_wdata;
    logic [7:0] m_buf[$];

    int n_ok, n_err, n_req, n_clr;
    logic [7:0] o_addr;
    logic [15:0] o_wdata;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_in = 0; m_wr = 0; m_ok = 0; m_err = 0; m_clr = 0;
        m_idle = 0; m_okc = 0; m_errc = 0; m_code = 0; m_buf.delete();
    endtask

    task automatic m_abort(logic [2:0] c);
        m_in = 0; m_wr = 0; m_buf.delete(); m_err = 1; m_code = c;
        if (m_errc < MAXC) m_errc++;
    endtask

    task automatic model(bit v, logic [7:0] d, bit bad, bit ack);
        bit le;
        int s;
        le = v && bad;
        m_ok = 0; m_err = 0; m_clr = le;
        if (m_wr) begin
            if (ack) begin
                m_wr = 0; m_ok = 1;
                if (m_okc < MAXC) m_okc++;
            end else if (le) m_abort(3);
            else if (v) m_abort(4);
            else begin
                m_idle++;
                if (m_idle == T) m_abort(5);
            end
        end else if (m_in) begin
            if (le) m_abort(3);
            else if (v) begin
                m_buf.push_back(d);
                m_idle = 0;
                if (m_buf.size() == 4) begin
                    s = 0;
                    foreach (m_buf[i]) s += m_buf[i];
                    if (s % 256 == 0) begin
                        m_wr = 1; m_in = 0;
                        m_addr = m_buf[0]; m_wdata = {m_buf[1], m_buf[2]};
                    end else m_abort(1);
                end
            end else begin
                m_idle++;
                if (m_idle == T) m_abort(2);
            end
        end else if (v && !le && d == 8'h55) begin
            m_in = 1; m_idle = 0; m_buf.delete();
        end
    endtask

    task automatic step(bit v, logic [7:0] d, bit fe, bit ce, bit ack);
        rx_valid = v; rx_data = d; rx_frame_error = fe; rx_chk_error = ce; cfg_ack = ack;
        @(posedge clk);
        model(v, d, fe | ce, ack);
        #1;
        check("cycle", {rx_clear, frame_ok, frame_err, busy, cfg_req, err_code, ok_cnt, err_cnt},
              {m_clr, m_ok, m_err, m_in | m_wr, m_wr, m_code, CW'(m_okc), CW'(m_errc)});
        if (cfg_req) check("cfg_bus", {cfg_addr, cfg_wdata}, {m_addr, m_wdata});
        n_ok += int'(frame_ok); n_err += int'(frame_err); n_clr += int'(rx_clear);
        if (cfg_req) begin
            n_req++; o_addr = cfg_addr; o_wdata = cfg_wdata;
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 8'h00, 0, 0, 0);
    endtask

    task automatic clr_obs();
        n_ok = 0; n_err = 0; n_req = 0; n_clr = 0; o_addr = 0; o_wdata = 0;
    endtask

    task automatic send_frame(logic [39:0] f);
        for (int b = 0; b < 5; b++) begin
            if (b != 0) idle(1);
            step(1, f[39-8*b -: 8], 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1; rx_valid = 0; cfg_ack = 0; rx_frame_error = 0; rx_chk_error = 0;
        @(posedge clk);
        m_reset();
        #1;
        check("reset", {rx_clear, cfg_req, frame_ok, frame_err, busy, err_code, ok_cnt, err_cnt, cfg_addr, cfg_wdata}, 64'd0);
        rst = 0;
    endtask

    typedef struct {
        logic [39:0] bytes;
        int ack_dly;
        int exp_ok, exp_err, exp_req, exp_okc, exp_errc;
        logic [2:0] exp_code;
        logic [7:0] exp_addr;
        logic [15:0] exp_wdata;
    } vec_t;
    vec_t vecs[5];

    logic [7:0] fb[5];
    int ack_at, stray, gap;

    initial begin
        vecs[0] = '{40'h55_10_12_34_AA,  2, 1, 0,  3, 1, 0, 3'd1 * 0, 8'h10, 16'h1234};
        vecs[1] = '{40'h55_10_12_34_AB,  2, 0, 1,  0, 1, 1, 3'd1,     8'h00, 16'h0000};
        vecs[2] = '{40'h55_01_00_05_FA,  0, 1, 0,  1, 2, 1, 3'd1,     8'h01, 16'h0005};
        vecs[3] = '{40'h00_FF_00_FF_00,  0, 0, 0,  0, 2, 1, 3'd1,     8'h00, 16'h0000};
        vecs[4] = '{40'h55_20_40_00_A0, -1, 0, 1,  T, 2, 2, 3'd5,     8'h20, 16'h4000};
        do_reset();
        foreach (vecs[i]) begin
            clr_obs();
            send_frame(vecs[i].bytes);
            for (int c = 0; c < T + 4; c++) step(0, 8'h00, 0, 0, vecs[i].ack_dly >= 0 && c == vecs[i].ack_dly);
            check($sformatf("vec%0d_pulses", i), {32'(n_ok), 32'(n_err)}, {32'(vecs[i].exp_ok), 32'(vecs[i].exp_err)});
            check($sformatf("vec%0d_req_cycles", i), n_req, vecs[i].exp_req);
            check($sformatf("vec%0d_code_cnts", i), {err_code, ok_cnt, err_cnt},
                  {vecs[i].exp_code, CW'(vecs[i].exp_okc), CW'(vecs[i].exp_errc)});
            if (vecs[i].exp_req > 0) check($sformatf("vec%0d_bus", i), {o_addr, o_wdata}, {vecs[i].exp_addr, vecs[i].exp_wdata});
        end

        do_reset();
        clr_obs();
        step(1, 8'h55, 0, 0, 0); step(1, 8'h20, 0, 0, 0);
        idle(T - 1);
        check("timeout_not_yet", n_err, 0);
        idle(1);
        check("timeout_abort", {32'(n_err), 29'd0, err_code}, {32'd1, 29'd0, 3'd2});
        clr_obs();
        send_frame(40'h55_01_00_05_FA);
        step(0, 8'h00, 0, 0, 1);
        check("after_timeout_ok", {32'(n_ok), 16'd0, o_wdata}, {32'd1, 16'd0, 16'h0005});

        clr_obs();
        step(1, 8'h55, 0, 0, 0);
        idle(T - 1);
        step(1, 8'h10, 0, 0, 0);
        check("byte_beats_timeout", {32'(n_err), 31'd0, busy}, {32'd0, 31'd0, 1'b1});
        idle(T);
        check("timeout_after_late_byte", {32'(n_err), 29'd0, err_code}, {32'd1, 29'd0, 3'd2});

        clr_obs();
        step(1, 8'h55, 0, 0, 0); step(1, 8'h10, 0, 0, 0); step(1, 8'h12, 1, 0, 0);
        check("line_err_frame", {n_clr, n_err, 29'd0, err_code}, {32'd1, 32'd1, 29'd0, 3'd3});
        clr_obs();
        step(1, 8'h55, 0, 1, 0);
        idle(2);
        check("line_err_idle", {n_clr, n_err, 29'd0, err_code, 31'd0, busy}, {32'd1, 32'd0, 29'd0, 3'd3, 31'd0, 1'b0});

        clr_obs();
        send_frame(40'h55_10_12_34_AA);
        idle(1);
        step(1, 8'h77, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        check("overrun", {n_ok, n_err, 29'd0, err_code, 31'd0, cfg_req}, {32'd0, 32'd1, 29'd0, 3'd4, 31'd0, 1'b0});

        clr_obs();
        send_frame(40'h55_10_12_34_AA);
        step(1, 8'h55, 0, 0, 1);
        send_frame(40'h10_12_34_AA_00);
        check("ack_beats_byte", {n_ok, n_err, n_req, 31'd0, busy}, {32'd1, 32'd0, 32'd1, 31'd0, 1'b0});

        send_frame(40'h55_10_12_34_AA);
        check("pre_reset_req", cfg_req, 1'b1);
        do_reset();

        for (int k = 0; k < MAXC + 2; k++) begin
            send_frame(40'h55_01_00_05_FA);
            step(0, 8'h00, 0, 0, 1);
        end
        check("ok_cnt_saturates", ok_cnt, {CW{1'b1}});

        for (int f = 0; f < 60; f++) begin
            fb[0] = ($urandom_range(9) == 0) ? 8'($urandom) : 8'h55;
            for (int k = 1; k < 4; k++) fb[k] = 8'($urandom);
            fb[4] = 8'(0 - (int'(fb[1]) + int'(fb[2]) + int'(fb[3])));
            if ($urandom_range(3) == 0) fb[4] = 8'($urandom);
            for (int k = 0; k < 5; k++) begin
                gap = ($urandom_range(29) == 0) ? T + 1 : int'($urandom_range(2));
                idle(gap);
                step(1, fb[k], $urandom_range(24) == 0, $urandom_range(49) == 0, 0);
            end
            ack_at = ($urandom_range(9) == 0) ? T + 10 : int'($urandom_range(4));
            stray  = ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1;
            for (int c = 0; c < T + 3; c++) step(c == stray, 8'($urandom), 0, 0, c == ack_at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
